// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: debounced start/stop and lap/clear buttons, BCD SS.cc counter, lap freeze.
// Optional build macro SW_SATURATE_EN: hold at 59.99 and pause instead of wrapping to 00.00.
module stopwatch_ctrl #(
  parameter int DEB_SAMPLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_100,
  input  logic       btn_ss,
  input  logic       btn_lc,
  input  logic [1:0] scan_sel,
  output logic [3:0] bcd_out,
  output logic       dp_out,
  output logic       running,
  output logic       lap_active,
  output logic       wrap_pulse
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2, LAP = 2'd3} state_t;

  state_t                 state_q, state_d;
  logic [1:0]             ss_sync_q, ss_sync_d, lc_sync_q, lc_sync_d;
  logic [DEB_SAMPLES-1:0] ss_sh_q, ss_sh_d, lc_sh_q, lc_sh_d;
  logic                   ss_deb_q, ss_deb_d, lc_deb_q, lc_deb_d;
  logic [15:0]            live_q, live_d, shown_q, shown_d;
  logic                   wrap_q, wrap_d;
  logic                   ss_evt, lc_evt, counting, sat_hit, clear;

  // Digits packed as {sec tens, sec ones, centisec tens, centisec ones}.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [3:0] c0, c1, s0, s1;
    {s1, s0, c1, c0} = v;
    if (c0 != 4'd9) c0 = c0 + 4'd1;
    else begin
      c0 = 4'd0;
      if (c1 != 4'd9) c1 = c1 + 4'd1;
      else begin
        c1 = 4'd0;
        if (s0 != 4'd9) s0 = s0 + 4'd1;
        else begin
          s0 = 4'd0;
          s1 = (s1 == 4'd5) ? 4'd0 : s1 + 4'd1;
        end
      end
    end
    return {s1, s0, c1, c0};
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ss_sync_q <= '0;
      lc_sync_q <= '0;
      ss_sh_q   <= '0;
      lc_sh_q   <= '0;
      ss_deb_q  <= 1'b0;
      lc_deb_q  <= 1'b0;
      live_q    <= '0;
      shown_q   <= '0;
      wrap_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ss_sync_q <= ss_sync_d;
      lc_sync_q <= lc_sync_d;
      ss_sh_q   <= ss_sh_d;
      lc_sh_q   <= lc_sh_d;
      ss_deb_q  <= ss_deb_d;
      lc_deb_q  <= lc_deb_d;
      live_q    <= live_d;
      shown_q   <= shown_d;
      wrap_q    <= wrap_d;
    end
  end

  // Debounce: level only moves once every tick-sampled bit agrees.
  always_comb begin
    ss_sync_d = {ss_sync_q[0], btn_ss};
    lc_sync_d = {lc_sync_q[0], btn_lc};
    ss_sh_d   = ss_sh_q;
    lc_sh_d   = lc_sh_q;
    if (tick_100) begin
      ss_sh_d = {ss_sh_q[DEB_SAMPLES-2:0], ss_sync_q[1]};
      lc_sh_d = {lc_sh_q[DEB_SAMPLES-2:0], lc_sync_q[1]};
    end
    ss_deb_d = ss_deb_q;
    if (&ss_sh_q)      ss_deb_d = 1'b1;
    else if (~|ss_sh_q) ss_deb_d = 1'b0;
    lc_deb_d = lc_deb_q;
    if (&lc_sh_q)      lc_deb_d = 1'b1;
    else if (~|lc_sh_q) lc_deb_d = 1'b0;
    ss_evt = ss_deb_d & ~ss_deb_q;
    lc_evt = lc_deb_d & ~lc_deb_q;
  end

  always_comb begin
    counting = tick_100 && (state_q == RUN || state_q == LAP);
    live_d   = live_q;
    wrap_d   = 1'b0;
    sat_hit  = 1'b0;
    clear    = 1'b0;
    state_d  = state_q;

    if (counting) begin
      if (live_q == 16'h5999) begin
        wrap_d = 1'b1;
`ifdef SW_SATURATE_EN
        sat_hit = 1'b1;
`else
        live_d = '0;
`endif
      end else begin
        live_d = bcd_inc(live_q);
      end
    end

    // Start/stop takes priority over lap/clear when both fire together.
    case (state_q)
      IDLE:    if (ss_evt) state_d = RUN;
      RUN:     if (ss_evt) state_d = PAUSE; else if (lc_evt) state_d = LAP;
      LAP:     if (ss_evt) state_d = PAUSE; else if (lc_evt) state_d = RUN;
      PAUSE: begin
        if (ss_evt) state_d = RUN;
        else if (lc_evt) begin
          state_d = IDLE;
          clear   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (sat_hit) state_d = PAUSE;
    if (clear)   live_d  = '0;

    // Shown digits track the next live value except while staying in LAP.
    shown_d = (state_q == LAP && state_d == LAP) ? shown_q : live_d;
  end

  always_comb begin
    case (scan_sel)
      2'd0:    bcd_out = shown_q[3:0];
      2'd1:    bcd_out = shown_q[7:4];
      2'd2:    bcd_out = shown_q[11:8];
      default: bcd_out = shown_q[15:12];
    endcase
  end

  assign dp_out     = (scan_sel == 2'd2);
  assign running    = (state_q == RUN) || (state_q == LAP);
  assign lap_active = (state_q == LAP);
  assign wrap_pulse = wrap_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl: stimulus queues expected snapshots, a monitor scans and compares them.
module tb_stopwatch_ctrl;

  localparam int DEB = 2;
`ifdef SW_SATURATE_EN
  localparam logic [15:0] BASE = 16'h0002;
`else
  localparam logic [15:0] BASE = 16'h0000;
`endif

  logic       clk = 1'b0;
  logic       rst_n, tick_100, btn_ss, btn_lc;
  logic [1:0] scan_sel;
  logic [3:0] bcd_out;
  logic       dp_out, running, lap_active, wrap_pulse;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       name;
    logic [15:0] dig;
    logic        run;
    logic        lap;
    logic        wrap;
  } exp_t;

  exp_t exp_q[$];

  stopwatch_ctrl #(.DEB_SAMPLES(DEB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick_100   (tick_100),
    .btn_ss     (btn_ss),
    .btn_lc     (btn_lc),
    .scan_sel   (scan_sel),
    .bcd_out    (bcd_out),
    .dp_out     (dp_out),
    .running    (running),
    .lap_active (lap_active),
    .wrap_pulse (wrap_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", nm, got, want);
    end
  endtask

  task automatic expect_now(input string nm, input logic [15:0] dig,
                            input logic run, input logic lap, input logic wrap);
    exp_t e;
    e.name = nm; e.dig = dig; e.run = run; e.lap = lap; e.wrap = wrap;
    exp_q.push_back(e);
  endtask

  // Monitor: on each falling edge, pop one expectation and scan all four digits.
  initial begin
    exp_t e;
    logic [15:0] seen;
    scan_sel = 2'd0;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        seen = '0;
        for (int s = 0; s < 4; s++) begin
          scan_sel = 2'(s);
          #1;
          seen[s*4 +: 4] = bcd_out;
          chk({e.name, ".dp"}, {31'd0, dp_out}, {31'd0, (s == 2)});
        end
        chk({e.name, ".digits"}, {16'd0, seen}, {16'd0, e.dig});
        chk({e.name, ".running"}, {31'd0, running}, {31'd0, e.run});
        chk({e.name, ".lap_active"}, {31'd0, lap_active}, {31'd0, e.lap});
        chk({e.name, ".wrap_pulse"}, {31'd0, wrap_pulse}, {31'd0, e.wrap});
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_tick();
    tick_100 = 1'b1;
    cycles(1);
    tick_100 = 1'b0;
    cycles(1);
  endtask

  task automatic ticks(input int n);
    repeat (n) do_tick();
  endtask

  task automatic press(input bit ss, input bit lc);
    if (ss) btn_ss = 1'b1;
    if (lc) btn_lc = 1'b1;
    cycles(2);
    ticks(DEB);
  endtask

  task automatic release_btn(input bit ss, input bit lc);
    if (ss) btn_ss = 1'b0;
    if (lc) btn_lc = 1'b0;
    cycles(2);
    ticks(DEB);
  endtask

  initial begin
    int wait_cnt;
    rst_n    = 1'b0;
    tick_100 = 1'b0;
    btn_ss   = 1'b1;
    btn_lc   = 1'b0;
    cycles(3);
    expect_now("reset", 16'h0000, 0, 0, 0);
    cycles(1);
    rst_n = 1'b1;

    // Button held through reset: one agreeing sample is not enough, the second starts RUN.
    cycles(2);
    do_tick();
    expect_now("one_sample", 16'h0000, 0, 0, 0);
    do_tick();
    expect_now("ss_after_reset", 16'h0000, 1, 0, 0);
    do_tick();
    expect_now("third_tick", 16'h0001, 1, 0, 0);
    release_btn(1, 0);
    ticks(147);
    expect_now("run_150", 16'h0150, 1, 0, 0);

    // One-sample glitch on start/stop.
    btn_ss = 1'b1;
    cycles(2);
    do_tick();
    btn_ss = 1'b0;
    cycles(2);
    ticks(2);
    expect_now("glitch", 16'h0153, 1, 0, 0);

    // Lap at 12.34, live keeps running, exit shows live.
    ticks(1079);
    press(0, 1);
    expect_now("lap_enter", 16'h1234, 1, 1, 0);
    release_btn(0, 1);
    expect_now("lap_hold", 16'h1234, 1, 1, 0);
    ticks(100);
    expect_now("lap_hold_100", 16'h1234, 1, 1, 0);
    press(0, 1);
    expect_now("lap_exit", 16'h1338, 1, 0, 0);
    release_btn(0, 1);
    expect_now("after_lap", 16'h1340, 1, 0, 0);

    // Top of range.
    ticks(4659);
    expect_now("at_5999", 16'h5999, 1, 0, 0);
    tick_100 = 1'b1;
    cycles(1);
`ifdef SW_SATURATE_EN
    expect_now("saturate", 16'h5999, 0, 0, 1);
    tick_100 = 1'b0;
    cycles(1);
    expect_now("saturate_after", 16'h5999, 0, 0, 0);
    press(0, 1);
    release_btn(0, 1);
    press(1, 0);
    release_btn(1, 0);
    expect_now("restart", BASE, 1, 0, 0);
`else
    expect_now("wrap", 16'h0000, 1, 0, 1);
    tick_100 = 1'b0;
    cycles(1);
    expect_now("wrap_after", 16'h0000, 1, 0, 0);
`endif

    // ss and lc events together, coinciding with a tick.
    btn_ss = 1'b1;
    btn_lc = 1'b1;
    cycles(2);
    ticks(DEB - 1);
    tick_100 = 1'b1;
    cycles(2);
    tick_100 = 1'b0;
    expect_now("both_on_tick", BASE + 16'h0003, 0, 0, 0);
    release_btn(1, 1);
    expect_now("pause_hold", BASE + 16'h0003, 0, 0, 0);
    press(0, 1);
    expect_now("clear", 16'h0000, 0, 0, 0);
    release_btn(0, 1);
    expect_now("idle_lc_release", 16'h0000, 0, 0, 0);

    // Asynchronous reset mid-RUN.
    press(1, 0);
    expect_now("run_again", 16'h0000, 1, 0, 0);
    release_btn(1, 0);
    ticks(5);
    expect_now("run_7", 16'h0007, 1, 0, 0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    expect_now("async_reset", 16'h0000, 0, 0, 0);
    cycles(2);
    rst_n = 1'b1;
    cycles(1);

    wait_cnt = 0;
    while (exp_q.size() != 0 && wait_cnt < 20) begin
      cycles(1);
      wait_cnt++;
    end
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
